// File: rtl/typhoon_pkg.sv
// Shared definitions for the tile pipeline: tile/framebuffer geometry, pixel type
// and the writeback FSM states.
package typhoon_pkg;

  localparam int TILE_DIM  = 8;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } tile_writeback_state_t;

endpackage

// File: rtl/tile_scan_counter.sv
// Row-major row/column walker over a DIM x DIM tile; exposes the values the
// counters take at the next edge so callers can precompute registered outputs.
module tile_scan_counter
  import typhoon_pkg::*;
#(
  parameter int DIM = TILE_DIM,
  parameter int CW  = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [CW-1:0] o_row_nx,
  output logic [CW-1:0] o_col_nx,
  output logic          o_last
);

  localparam logic [CW-1:0] MAX = CW'(DIM - 1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  assign o_last = (r_row == MAX) && (r_col == MAX);

  always_comb begin
    o_row_nx = r_row;
    o_col_nx = r_col;
    if (i_clear) begin
      o_row_nx = '0;
      o_col_nx = '0;
    end else if (i_advance) begin
      if (r_col == MAX) begin
        o_col_nx = '0;
        o_row_nx = (r_row == MAX) ? '0 : r_row + CW'(1);
      end else begin
        o_col_nx = r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= o_row_nx;
      r_col <= o_col_nx;
    end
  end

endmodule

// File: rtl/tile_writeback.sv
// Streams one 8x8 colour tile into the linear framebuffer, one pixel per accepted write.
// Optional screen-edge clipping under `TILE_WRITEBACK_CLIP_EN.
module tile_writeback #(
  parameter int tileDim   = typhoon_pkg::TILE_DIM,
  parameter int FB_WIDTH  = typhoon_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = typhoon_pkg::FB_HEIGHT,
  parameter int ADDR_W    = 20
) (
  input  logic                                    BOARD_CLK,
  input  logic                                    RESET,
  input  logic [tileDim-1:0][tileDim-1:0][15:0]   cBufferTile0,
  input  logic [tileDim-1:0][tileDim-1:0][15:0]   cBufferTile1,
  input  logic                                    flushTileID,
  input  logic [9:0]                              flushxOffset,
  input  logic [9:0]                              flushyOffset,
  input  logic                                    startFlush,
  output logic [ADDR_W-1:0]                       memAddr,
  output logic [15:0]                             memData,
  output logic                                    memWrite,
  input  logic                                    memReady,
  output logic                                    busy,
  output logic                                    doneFlushing
);

  import typhoon_pkg::*;

  localparam int CW = (tileDim > 1) ? $clog2(tileDim) : 1;

  tile_writeback_state_t r_state, w_state_nx;

  logic              r_tile;
  logic [9:0]        r_xoff;
  logic [9:0]        r_yoff;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  pixel_t            r_data;

  logic              w_start;
  logic              w_adv;
  logic              w_last;
  logic              w_clip_nx;
  logic              w_tile_nx;
  logic [9:0]        w_xoff_nx;
  logic [9:0]        w_yoff_nx;
  logic [CW-1:0]     w_row_nx;
  logic [CW-1:0]     w_col_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  pixel_t            w_pix_nx;

  assign w_start = (r_state == IDLE) && startFlush;
  // A clipped pixel is never presented (r_wr low), so it advances without memReady.
  assign w_adv   = (r_state == WRITE) && (!r_wr || memReady);

  tile_scan_counter #(.DIM(tileDim), .CW(CW)) u_scan (
    .i_clk     (BOARD_CLK),
    .i_rst     (RESET),
    .i_clear   (w_start),
    .i_advance (w_adv),
    .o_row_nx  (w_row_nx),
    .o_col_nx  (w_col_nx),
    .o_last    (w_last)
  );

  assign w_tile_nx = w_start ? flushTileID  : r_tile;
  assign w_xoff_nx = w_start ? flushxOffset : r_xoff;
  assign w_yoff_nx = w_start ? flushyOffset : r_yoff;

  assign w_addr_nx = (ADDR_W'(w_yoff_nx) + ADDR_W'(w_row_nx)) * ADDR_W'(FB_WIDTH)
                   + ADDR_W'(w_xoff_nx) + ADDR_W'(w_col_nx);
  assign w_pix_nx  = w_tile_nx ? cBufferTile1[w_col_nx][w_row_nx]
                               : cBufferTile0[w_col_nx][w_row_nx];

`ifdef TILE_WRITEBACK_CLIP_EN
  logic [10:0] w_px_nx;
  logic [10:0] w_py_nx;
  assign w_px_nx   = {1'b0, w_xoff_nx} + 11'(w_col_nx);
  assign w_py_nx   = {1'b0, w_yoff_nx} + 11'(w_row_nx);
  assign w_clip_nx = (w_px_nx >= 11'(FB_WIDTH)) || (w_py_nx >= 11'(FB_HEIGHT));
`else
  assign w_clip_nx = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (startFlush) w_state_nx = WRITE;
      WRITE:   if (w_adv && w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Outputs are loaded with the pixel the counters move to, so they stay frozen under backpressure.
  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      r_tile <= 1'b0;
      r_xoff <= '0;
      r_yoff <= '0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wr <= (w_state_nx == WRITE) && !w_clip_nx;
      if (w_start) begin
        r_tile <= flushTileID;
        r_xoff <= flushxOffset;
        r_yoff <= flushyOffset;
      end
      if (w_start || w_adv) begin
        r_addr <= w_addr_nx;
        r_data <= w_pix_nx;
      end
    end
  end

  assign memAddr      = r_addr;
  assign memData      = r_data;
  assign memWrite     = r_wr;
  assign busy         = (r_state != IDLE);
  assign doneFlushing = (r_state == DONE);

endmodule

// File: tb/tb_tile_writeback.sv
// Directed bench for tile_writeback: pixel-index model of the flush plus literal spot checks.
module tb_tile_writeback;

  logic                       BOARD_CLK = 1'b0;
  logic                       RESET = 1'b1;
  logic [7:0][7:0][15:0]      cBufferTile0;
  logic [7:0][7:0][15:0]      cBufferTile1;
  logic                       flushTileID = 1'b0;
  logic [9:0]                 flushxOffset = '0;
  logic [9:0]                 flushyOffset = '0;
  logic                       startFlush = 1'b0;
  logic [19:0]                memAddr;
  logic [15:0]                memData;
  logic                       memWrite;
  logic                       memReady = 1'b0;
  logic                       busy;
  logic                       doneFlushing;

  int vectors = 0;
  int miscompares = 0;

`ifdef TILE_WRITEBACK_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  tile_writeback dut (
    .BOARD_CLK    (BOARD_CLK),
    .RESET        (RESET),
    .cBufferTile0 (cBufferTile0),
    .cBufferTile1 (cBufferTile1),
    .flushTileID  (flushTileID),
    .flushxOffset (flushxOffset),
    .flushyOffset (flushyOffset),
    .startFlush   (startFlush),
    .memAddr      (memAddr),
    .memData      (memData),
    .memWrite     (memWrite),
    .memReady     (memReady),
    .busy         (busy),
    .doneFlushing (doneFlushing)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  // Model: phase 0 idle, 1 writing pixel index m_k (x = k%8, y = k/8), 2 done.
  int   m_phase = 0;
  int   m_k = 0;
  int   m_xo = 0;
  int   m_yo = 0;
  logic m_tid = 1'b0;

  int   n_wr = 0;
  int   n_done = 0;
  int   n_a5 = 0;
  int   first_addr = -1;
  int   first_data = -1;
  int   last_addr = -1;
  int   last_data = -1;

  function automatic bit visible(input int xo, input int yo, input int k);
    return !(CLIP && ((xo + k % 8 >= 640) || (yo + k / 8 >= 480)));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge BOARD_CLK) begin
    bit   exp_wr;
    bit   ok;
    int   x;
    int   y;
    int   ea;
    logic [15:0] ed;
    if (RESET) begin
      m_phase = 0;
      vectors++;
      if (memWrite !== 1'b0 || busy !== 1'b0 || doneFlushing !== 1'b0 ||
          memAddr !== 20'd0 || memData !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: wr=%b busy=%b done=%b addr=%0d data=%h, expected all 0",
                 memWrite, busy, doneFlushing, memAddr, memData);
      end
    end else begin
      x      = m_k % 8;
      y      = m_k / 8;
      ea     = (m_yo + y) * 640 + (m_xo + x);
      ed     = m_tid ? cBufferTile1[x][y] : cBufferTile0[x][y];
      exp_wr = (m_phase == 1) && visible(m_xo, m_yo, m_k);
      ok = (busy === (m_phase != 0)) && (doneFlushing === (m_phase == 2)) &&
           (memWrite === exp_wr);
      if (exp_wr) ok = ok && (memAddr === 20'(ea)) && (memData === ed);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL cycle_model k=%0d: wr=%b busy=%b done=%b addr=%0d data=%h, expected wr=%b busy=%b done=%b addr=%0d data=%h",
                 m_k, memWrite, busy, doneFlushing, memAddr, memData,
                 exp_wr, (m_phase != 0), (m_phase == 2), ea, ed);
      end
      if (memWrite && memReady) begin
        if (n_wr == 0) begin
          first_addr = int'(memAddr);
          first_data = int'(memData);
        end
        last_addr = int'(memAddr);
        last_data = int'(memData);
        if (memData == 16'hA5A5) n_a5++;
        n_wr++;
      end
      if (doneFlushing) n_done++;
      case (m_phase)
        0: if (startFlush) begin
             m_phase = 1;
             m_k     = 0;
             m_xo    = int'(flushxOffset);
             m_yo    = int'(flushyOffset);
             m_tid   = flushTileID;
           end
        1: if (!visible(m_xo, m_yo, m_k) || memReady) begin
             if (m_k == 63) m_phase = 2;
             else m_k++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic clear_stats();
    n_wr = 0; n_done = 0; n_a5 = 0;
    first_addr = -1; first_data = -1; last_addr = -1; last_data = -1;
  endtask

  // rmode 0: ready always high; 1: ready pattern 1,0,0,1. poke_at/rst_at < 0 disable.
  task automatic run_flush(input logic tid, input int xo, input int yo,
                           input int rmode, input int poke_at, input int rst_at);
    int cyc;
    clear_stats();
    @(posedge BOARD_CLK); #1;
    flushTileID  = tid;
    flushxOffset = 10'(xo);
    flushyOffset = 10'(yo);
    startFlush   = 1'b1;
    memReady     = 1'b1;
    @(posedge BOARD_CLK); #1;
    startFlush = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 2000) begin
      memReady   = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      startFlush = (poke_at >= 0) && (n_wr == poke_at);
      if (rst_at >= 0 && n_wr >= rst_at) begin
        RESET = 1'b1;
        #2;
        chk("midrst_memWrite", memWrite, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", doneFlushing, 0);
        @(posedge BOARD_CLK); #1;
        @(posedge BOARD_CLK); #1;
        RESET = 1'b0;
        break;
      end
      @(posedge BOARD_CLK); #1;
      cyc++;
    end
    startFlush = 1'b0;
    if (cyc >= 2000) chk("flush_timeout", 1, 0);
    repeat (3) @(posedge BOARD_CLK);
    #1;
  endtask

  initial begin
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        cBufferTile0[x][y] = 16'(x + 8 * y);
        cBufferTile1[x][y] = 16'hFFFF;
      end
    repeat (2) @(posedge BOARD_CLK);
    #1;
    RESET = 1'b0;
    chk("reset_memWrite", memWrite, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", doneFlushing, 0);
    chk("reset_memAddr", memAddr, 0);

    run_flush(1'b0, 16, 8, 0, -1, -1);
    chk("basic_first_addr", first_addr, 5136);
    chk("basic_first_data", first_data, 0);
    chk("basic_last_addr", last_addr, 9623);
    chk("basic_last_data", last_data, 63);
    chk("basic_writes", n_wr, 64);
    chk("basic_done_pulses", n_done, 1);
    chk("basic_busy_after", busy, 0);

    run_flush(1'b0, 16, 8, 1, -1, -1);
    chk("bp_writes", n_wr, 64);
    chk("bp_done_pulses", n_done, 1);
    chk("bp_last_data", last_data, 63);

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        cBufferTile0[x][y] = 16'h0000;
        cBufferTile1[x][y] = 16'hA5A5;
      end
    run_flush(1'b1, 16, 8, 0, -1, -1);
    chk("tilesel_a5_writes", n_a5, 64);
    chk("tilesel_writes", n_wr, 64);

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) cBufferTile0[x][y] = 16'(x + 8 * y);
    run_flush(1'b0, 16, 8, 0, 10, -1);
    chk("ignstart_writes", n_wr, 64);
    chk("ignstart_done_pulses", n_done, 1);

    run_flush(1'b0, 16, 8, 0, -1, 20);
    chk("midrst_writes", n_wr, 20);
    chk("midrst_no_done", n_done, 0);
    run_flush(1'b0, 16, 8, 0, -1, -1);
    chk("restart_first_addr", first_addr, 5136);
    chk("restart_first_data", first_data, 0);
    chk("restart_writes", n_wr, 64);

    run_flush(1'b0, 636, 476, 0, -1, -1);
    chk("edge_first_addr", first_addr, 305276);
    chk("edge_done_pulses", n_done, 1);
    if (CLIP) begin
      chk("clip_writes", n_wr, 16);
      chk("clip_last_addr", last_addr, 307199);
    end else begin
      chk("noclip_writes", n_wr, 64);
      chk("noclip_last_addr", last_addr, 309763);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
